// File: rtl/b1_pipe.sv
// b1_pipe: multi-lane pipelined b1 evaluator.
//
// Each of LANES lanes evaluates the b1 equations on a 3-bit input
// (a=pi[3i], b=pi[3i+1], c=pi[3i+2]) and produces a 4-bit result
// {po3,po2,po1,po0} at po[4i +: 4]. Results are written as one word into a
// DEPTH-entry FIFO behind valid/ready handshakes. A saturating counter
// tracks accepted words.
//
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   pi, in_valid/in_ready input word and handshake (in_ready = !full)
//   po, out_valid/out_ready FIFO head word and handshake (out_valid = !empty)
//   cnt_clr, acc_cnt      synchronous clear, saturating accept count
//   par                   per-lane even parity of the head word
//                         (only when B1_PIPE_PARITY_EN is defined)
//
// Optional feature macro: B1_PIPE_PARITY_EN
module b1_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [3*LANES-1:0]   pi,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*LANES-1:0]   po,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     acc_cnt
`ifdef B1_PIPE_PARITY_EN
  ,
  output logic [LANES-1:0]     par
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [4*LANES-1:0]   res;
  logic [4*LANES-1:0]   mem [DEPTH];

  // Extra pointer MSB differs only when the writer has lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_ready & ~empty;

  // Lane equations.
  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      logic a, b, c;
      a = pi[3*i];
      b = pi[3*i+1];
      c = pi[3*i+2];
      res[4*i +: 4] = {~c, (b ^ c) & (a ^ c), a ^ b, c};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= res;
  end

  assign po = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt <= '0;
    end else if (cnt_clr) begin
      acc_cnt <= '0;
    end else if (push && (acc_cnt != '1)) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

`ifdef B1_PIPE_PARITY_EN
  logic [LANES-1:0] par_res;
  logic [LANES-1:0] par_mem [DEPTH];

  always_comb begin
    par_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      par_res[i] = ^res[4*i +: 4];
    end
  end

  always_ff @(posedge clock) begin
    if (push) par_mem[wr_ptr[AW-1:0]] <= par_res;
  end

  // Storage is not reset, so gate with empty to give par=0 out of reset.
  assign par = empty ? '0 : par_mem[rd_ptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_b1_pipe.sv
// Testbench for b1_pipe: directed stimulus against a queue-based model of
// the FIFO, the lane equations and the saturating counters. A second
// instance with CNT_W=4 exercises counter saturation and clear priority.
module tb_b1_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] pi = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] po;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] acc_cnt;

  logic        c_valid = 1'b0;
  logic        c_clr = 1'b0;
  logic        c_in_ready;
  logic [15:0] c_po;
  logic        c_out_valid;
  logic [3:0]  c_acc;

`ifdef B1_PIPE_PARITY_EN
  logic [3:0]  par;
  logic [3:0]  c_par;
`endif

  always #5 clock = ~clock;

  b1_pipe #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .pi(pi), .in_valid(in_valid),
    .in_ready(in_ready), .po(po), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .acc_cnt(acc_cnt)
`ifdef B1_PIPE_PARITY_EN
    , .par(par)
`endif
  );

  b1_pipe #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(4)) dut_c (
    .clock(clock), .reset_n(reset_n), .pi(pi), .in_valid(c_valid),
    .in_ready(c_in_ready), .po(c_po), .out_valid(c_out_valid),
    .out_ready(1'b1), .cnt_clr(c_clr), .acc_cnt(c_acc)
`ifdef B1_PIPE_PARITY_EN
    , .par(c_par)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] q[$];
  int          cnt = 0;
  int          occ_c = 0;
  int          cnt_c = 0;

  // b1 equations applied lane by lane.
  function automatic logic [15:0] b1_word(input logic [11:0] v);
    logic [15:0] r;
    logic a, b, c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = v[3*i]; b = v[3*i+1]; c = v[3*i+2];
      r[4*i+0] = c;
      r[4*i+1] = a ^ b;
      r[4*i+2] = (b ^ c) & (a ^ c);
      r[4*i+3] = ~c;
    end
    return r;
  endfunction

  function automatic logic [3:0] par_of(input logic [15:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^w[4*i +: 4];
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("po", {16'd0, po}, {16'd0, q[0]});
`ifdef B1_PIPE_PARITY_EN
      chk("par", {28'd0, par}, {28'd0, par_of(q[0])});
`endif
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
    chk("acc_cnt", {16'd0, acc_cnt}, cnt);
    chk("c_in_ready", {31'd0, c_in_ready}, {31'd0, occ_c < DEPTH});
    chk("c_acc", {28'd0, c_acc}, cnt_c);
  endtask

  // One clock: predict the edge's effect from the current inputs, then
  // sample outputs 1 time unit after the edge.
  task automatic step();
    bit acc, pp, acc_c, pp_c;
    logic [15:0] w;
    acc   = in_valid && (q.size() < DEPTH);
    pp    = out_ready && (q.size() > 0);
    acc_c = c_valid && (occ_c < DEPTH);
    pp_c  = (occ_c > 0);
    w     = b1_word(pi);
    @(posedge clock);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(w);
    if (cnt_clr) cnt = 0;
    else if (acc && cnt < 65535) cnt++;
    occ_c = occ_c + (acc_c ? 1 : 0) - (pp_c ? 1 : 0);
    if (c_clr) cnt_c = 0;
    else if (acc_c && cnt_c < 15) cnt_c++;
    check_all();
  endtask

  initial begin
    // Pin the model against hand-computed lane results.
    chk("model_lanes", {16'd0, b1_word(12'h063)}, 32'h8A5C);
    chk("model_par", {28'd0, par_of(b1_word(12'h063))}, 32'h8);

    #12 reset_n = 1'b1;
    step();   // idle after reset

    // Queue 3 words, then reset asynchronously mid-cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pi = 12'(16'h0A5 * (i + 1));
      step();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_acc_cnt", {16'd0, acc_cnt}, 32'd0);
    q.delete(); cnt = 0; occ_c = 0; cnt_c = 0;
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b1;

    // First word after release is the lane-function vector.
    pi = 12'h063; in_valid = 1'b1;
    step();
    chk("lane_po", {16'd0, po}, 32'h8A5C);
`ifdef B1_PIPE_PARITY_EN
    chk("lane_par", {28'd0, par}, 32'h8);
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    step();   // drain

    // Backpressure: fill with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pi = 12'($urandom);
      step();
    end
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_acc_cnt", {16'd0, acc_cnt}, 32'd5);
    // Full with simultaneous pop: pop only, occupancy 3.
    out_ready = 1'b1;
    step();
    chk("bp_occ3", q.size(), 32'd3);
    chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: clear counter, then 100 back-to-back words.
    cnt_clr = 1'b1; in_valid = 1'b0;
    step();
    cnt_clr = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pi = 12'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("stream_acc_cnt", {16'd0, acc_cnt}, 32'd100);
    step();
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // Counter saturation and clear priority on the CNT_W=4 instance.
    c_valid = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", {28'd0, c_acc}, 32'd15);
    c_clr = 1'b1;
    step();
    chk("cnt_clr", {28'd0, c_acc}, 32'd0);
    c_clr = 1'b0;
    step();
    chk("cnt_after_clr", {28'd0, c_acc}, 32'd1);
    c_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/b1_pipe.md
# b1_pipe

Parametrised, pipelined multi-lane successor to the `b1` combinational benchmark function. Each of `LANES` independent 3-bit input vectors is evaluated with the b1 output equations. Results are buffered in a `DEPTH`-entry output FIFO behind valid/ready handshakes. A saturating accepted-word counter supports throughput checks in the benchmark harness.

## Interface
Parameters:
- `LANES`, 4, number of independent 3-bit evaluation lanes (≥1)
- `DEPTH`, 4, output FIFO entries (power of two, ≥2)
- `CNT_W`, 16, width of accepted-word counter

Ports:
- `clock`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pi`  in  3*LANES  lane i inputs: a=`pi[3i]`, b=`pi[3i+1]`, c=`pi[3i+2]`
- `in_valid`  in  1  `pi` holds a word to accept
- `in_ready`  out  1  block can accept this cycle
- `po`  out  4*LANES  lane i results: `po[4i+0]`=po0, `[4i+1]`=po1, `[4i+2]`=po2, `[4i+3]`=po3
- `out_valid`  out  1  `po` holds the FIFO head word
- `out_ready`  in  1  consumer takes the head this cycle
- `cnt_clr`  in  1  synchronous clear of `acc_cnt`
- `acc_cnt`  out  CNT_W  saturating count of accepted words
- `par`  out  LANES  per-lane even parity; present only with `B1_PIPE_PARITY_EN`

## Operation
- Lane function, per lane:
  - po0 = c
  - po3 = ~c
  - po1 = a ^ b
  - po2 = (b ^ c) & (a ^ c)
- Accept: `in_valid & in_ready`. All lanes are computed combinationally from `pi` and written as one word at the FIFO tail.
- Pop: `out_valid & out_ready` advances the head.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers. Pointers wrap modulo DEPTH; the extra MSB distinguishes full from empty.
- `in_ready` = !full. It is combinational from pointers only and never depends on `out_ready`. When full, a simultaneous pop does not enable a push that cycle.
- `out_valid` = !empty. `po` = FIFO head word; its value is don't-care while `out_valid`=0.
- Empty with push: the word is stored. It is not bypassed to `po` in the same cycle.
- Push and pop in the same cycle (not full, not empty): both pointers advance and the occupancy is unchanged.
- `acc_cnt`:
  - +1 per accept; saturates at 2^CNT_W−1.
  - `cnt_clr` forces 0 and has priority over a same-cycle accept; that accept is not counted.
- Reset (async assert, any time, mid-transfer included):
  - pointers → 0, FIFO empty
  - `out_valid`=0, `in_ready`=1, `acc_cnt`=0, `par`=0
  - FIFO storage contents are not reset.
  - Release is synchronous to `clock`; the first accept is possible on the first edge after deassertion.

## Timing
- Latency: a word accepted at edge k is valid on `po` with `out_valid`=1 after edge k (visible in cycle k+1), provided the FIFO was empty.
- Sustained throughput: 1 word/cycle while `out_ready`=1.
- With `out_ready`=0, exactly DEPTH words are accepted, then `in_ready` falls after the DEPTH-th accept edge.
- After a pop from full, `in_ready` rises in the following cycle.
- `po`, `par` and `out_valid` are registered or pointer-derived outputs with no combinational path from `pi`. `in_ready` has no combinational path from `out_ready`.

## Configuration
- `B1_PIPE_PARITY_EN` defined:
  - each FIFO entry also stores `par[i]` = po0^po1^po2^po3 of lane i, which equals ~(po1^po2);
  - `par` is output aligned with `po`;
  - `par` resets to 0 and is don't-care when `out_valid`=0.
- Not defined: the `par` port and its storage are absent; all other behaviour is identical.

## Test plan
- Reset/idle: assert `reset_n`=0 mid-stream with 3 words queued → `out_valid`=0, `in_ready`=1, `acc_cnt`=0 immediately. After release, the first `po` word is the first one pushed post-reset.
- Lane function, LANES=4: `pi` lanes (a,b,c) = (1,1,0), (0,0,1), (1,0,0), (0,0,0) → lane nibbles {po3,po2,po1,po0} = 1100, 0101, 1010, 1000. With parity enabled, `par` = 0,0,0,1.
- Backpressure: `out_ready`=0, `in_valid`=1 continuously, DEPTH=4 → 4 accepts, then `in_ready`=0. Raise `out_ready` for 1 cycle → one pop, `in_ready`=1 next cycle, and words drain in order.
- Streaming: `in_valid`=`out_ready`=1 for 100 cycles of random `pi` → 100 words output in order, each one cycle after acceptance, and `acc_cnt`=100.
- Full with simultaneous pop: while full, `in_valid`=1 and `out_ready`=1 → pop occurs, no push that cycle, occupancy becomes 3.
- Counter: CNT_W=4, 20 accepts → `acc_cnt` holds 15. Then `cnt_clr`=1 with a same-cycle accept → `acc_cnt`=0; the next accept gives 1.
